// File: rtl/ipsxe_fft_xk_capture.sv
// ipsxe_fft_xk_capture
//   Captures whole FFT result frames from the xk AXI4-Stream into a two-bank
//   ping-pong buffer. A display/UART reader fetches bins from the oldest
//   committed bank by address and releases it when done. Framing errors and
//   dropped frames are reported through sticky flags.
//
//   Optional feature macro: IPSXE_FFT_CAPTURE_INDEX_CHK_EN
//     When defined, every beat's tuser bin index must match the beat counter.
//     A mismatch discards the frame being written.
//
//   Handshake: the xk stream has no backpressure. A beat transfers on every
//   enabled clock where i_axi4s_data_tvalid is high. A read transfers on every
//   enabled clock where i_rd_req is high while o_frame_ready is high, and
//   o_rd_valid answers it one enabled clock later. i_frame_release is a
//   single-cycle strobe that counts only while o_frame_ready is high.
//
//   o_dbg_state exposes the write FSM: 0 = IDLE, 1 = WRITE, 2 = DROP.
module ipsxe_fft_xk_capture #(
  parameter int LOG2_FFT_LEN  = 10,
  parameter int OUTPUT_WIDTH  = 27,
  parameter int DATAOUT_WIDTH = 32,
  parameter int USER_WIDTH    = 16
) (
  input  logic                        i_aclk,
  input  logic                        i_aresetn,
  input  logic                        i_aclken,
  input  logic                        i_axi4s_data_tvalid,
  input  logic [2*DATAOUT_WIDTH-1:0]  i_axi4s_data_tdata,
  input  logic                        i_axi4s_data_tlast,
  input  logic [USER_WIDTH-1:0]       i_axi4s_data_tuser,
  input  logic                        i_rd_req,
  input  logic [LOG2_FFT_LEN-1:0]     i_rd_addr,
  input  logic                        i_frame_release,
  output logic                        o_rd_valid,
  output logic [OUTPUT_WIDTH-1:0]     o_rd_re,
  output logic [OUTPUT_WIDTH-1:0]     o_rd_im,
  output logic [7:0]                  o_blk_exp,
  output logic                        o_frame_ready,
  output logic [15:0]                 o_frame_cnt,
  output logic                        o_err,
  output logic                        o_ovf,
  output logic [1:0]                  o_dbg_state
);

  localparam int MW = 2 * OUTPUT_WIDTH;
  localparam logic [LOG2_FFT_LEN-1:0] CNT_LAST = '1;
  localparam logic [LOG2_FFT_LEN-1:0] CNT_ONE  = LOG2_FFT_LEN'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [LOG2_FFT_LEN-1:0]   cnt_q, cnt_d;
  logic                      cur_bank_q, cur_bank_d;   // bank of the frame in flight
  logic                      pref_bank_q, pref_bank_d; // bank to use when both are free
  logic                      rd_bank_q, rd_bank_d;     // oldest committed bank
  logic [1:0]                full_q, full_d;           // committed, not yet released
  logic [1:0][7:0]           bank_exp_q, bank_exp_d;
  logic [15:0]               frame_cnt_q, frame_cnt_d;
  logic                      err_q, err_d;
  logic                      ovf_q, ovf_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [OUTPUT_WIDTH-1:0]   rd_re_q, rd_re_d;
  logic [OUTPUT_WIDTH-1:0]   rd_im_q, rd_im_d;

  // Two banks of N bins; each entry is {imag, real} with the padding dropped.
  logic [MW-1:0]             mem [2**(LOG2_FFT_LEN+1)];

  logic                      beat;
  logic                      rel;
  logic                      take;
  logic                      wb;
  logic                      commit;
  logic                      idx_ok;
  logic                      wr_en;
  logic [LOG2_FFT_LEN:0]     wr_addr;
  logic [MW-1:0]             wr_data;
  logic [MW-1:0]             rd_word;
  logic [7:0]                blk_in;
  logic                      unused_bits;

  assign beat    = i_aclken & i_axi4s_data_tvalid;
  assign rel     = i_aclken & i_frame_release & (|full_q);
  assign blk_in  = i_axi4s_data_tuser[USER_WIDTH-1 -: 8];
  assign wr_data = {i_axi4s_data_tdata[DATAOUT_WIDTH+OUTPUT_WIDTH-1:DATAOUT_WIDTH],
                    i_axi4s_data_tdata[OUTPUT_WIDTH-1:0]};
  assign rd_word = mem[{rd_bank_q, i_rd_addr}];

`ifdef IPSXE_FFT_CAPTURE_INDEX_CHK_EN
  logic [LOG2_FFT_LEN-1:0] tuser_idx;
  assign tuser_idx = i_axi4s_data_tuser[LOG2_FFT_LEN-1:0];
  assign idx_ok    = (tuser_idx == cnt_q);
`else
  assign idx_ok    = 1'b1;
`endif

  // Sign-extension padding and the tuser bits between index and blk_exp carry no information here.
  assign unused_bits = ^{i_axi4s_data_tdata, i_axi4s_data_tuser};

  // Next-state logic for the write FSM, bank bookkeeping and the read port.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_bank_d  = cur_bank_q;
    pref_bank_d = pref_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    bank_exp_d  = bank_exp_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    rd_valid_d  = rd_valid_q;
    rd_re_d     = rd_re_q;
    rd_im_d     = rd_im_q;
    take        = 1'b0;
    wb          = cur_bank_q;
    commit      = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (beat) begin
          if (!(&full_q)) begin
            take       = 1'b1;
            wb         = full_q[pref_bank_q] ? ~pref_bank_q : pref_bank_q;
            cur_bank_d = wb;
          end else begin
            // No free bank: the whole frame is dropped.
            ovf_d   = 1'b1;
            state_d = i_axi4s_data_tlast ? S_IDLE : S_DROP;
          end
        end
      end
      S_WRITE: begin
        if (beat) begin
          take = 1'b1;
        end
      end
      S_DROP: begin
        if (beat && i_axi4s_data_tlast) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One accepted beat of the frame being written; cnt_q is 0 for the first beat.
    if (take) begin
      wr_en = 1'b1;
      if (!idx_ok) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = i_axi4s_data_tlast ? S_IDLE : S_DROP;
      end else if (i_axi4s_data_tlast && (cnt_q == CNT_LAST)) begin
        commit  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end else if (i_axi4s_data_tlast) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end else if (cnt_q == CNT_LAST) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_DROP;
      end else begin
        cnt_d   = cnt_q + CNT_ONE;
        state_d = S_WRITE;
      end
    end

    // Release first so a same-cycle commit sees the freed bank.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      pref_bank_d       = rd_bank_q;
    end

    if (commit) begin
      full_d[wb]     = 1'b1;
      bank_exp_d[wb] = blk_in;
      frame_cnt_d    = frame_cnt_q + 16'd1;
      if (!full_d[~wb]) begin
        rd_bank_d = wb;
      end
      if (!rel) begin
        pref_bank_d = ~wb;
      end
    end

    if (i_aclken) begin
      rd_valid_d = i_rd_req & (|full_q);
      if (i_rd_req && (|full_q)) begin
        rd_re_d = rd_word[OUTPUT_WIDTH-1:0];
        rd_im_d = rd_word[MW-1:OUTPUT_WIDTH];
      end
    end
  end

  // Control and output registers; nothing advances while i_aclken is low.
  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_bank_q  <= 1'b0;
      pref_bank_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      bank_exp_q  <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_re_q     <= '0;
      rd_im_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_bank_q  <= cur_bank_d;
      pref_bank_q <= pref_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      bank_exp_q  <= bank_exp_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      rd_valid_q  <= rd_valid_d;
      rd_re_q     <= rd_re_d;
      rd_im_q     <= rd_im_d;
    end
  end

  // Bin storage; contents need no reset because the bank flags gate every read.
  always_ff @(posedge i_aclk) begin
    if (wr_en) begin
      mem[{wb, cnt_q}] <= wr_data;
    end
  end

  assign wr_addr       = {wb, cnt_q};
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_re       = rd_re_q;
  assign o_rd_im       = rd_im_q;
  assign o_blk_exp     = bank_exp_q[rd_bank_q];
  assign o_frame_ready = |full_q;
  assign o_frame_cnt   = frame_cnt_q;
  assign o_err         = err_q;
  assign o_ovf         = ovf_q;
  assign o_dbg_state   = state_q;

  logic unused_wr_addr;
  assign unused_wr_addr = ^wr_addr;

endmodule

// File: tb/tb_ipsxe_fft_xk_capture.sv
// Directed bench for ipsxe_fft_xk_capture: frame capture, ping-pong overflow,
// framing errors, commit/release collision, clock enable and mid-frame reset.
module tb_ipsxe_fft_xk_capture;

  localparam int LOG2 = 10;
  localparam int N    = 1024;
  localparam int OW   = 27;
  localparam int DW   = 32;
  localparam int UW   = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              aclken;
  logic              tvalid;
  logic [2*DW-1:0]   tdata;
  logic              tlast;
  logic [UW-1:0]     tuser;
  logic              rd_req;
  logic [LOG2-1:0]   rd_addr;
  logic              frame_release;
  logic              rd_valid;
  logic [OW-1:0]     rd_re;
  logic [OW-1:0]     rd_im;
  logic [7:0]        blk_exp;
  logic              frame_ready;
  logic [15:0]       frame_cnt;
  logic              err;
  logic              ovf;
  logic [1:0]        dbg_state;

  ipsxe_fft_xk_capture dut (
    .i_aclk              (clk),
    .i_aresetn           (rst_n),
    .i_aclken            (aclken),
    .i_axi4s_data_tvalid (tvalid),
    .i_axi4s_data_tdata  (tdata),
    .i_axi4s_data_tlast  (tlast),
    .i_axi4s_data_tuser  (tuser),
    .i_rd_req            (rd_req),
    .i_rd_addr           (rd_addr),
    .i_frame_release     (frame_release),
    .o_rd_valid          (rd_valid),
    .o_rd_re             (rd_re),
    .o_rd_im             (rd_im),
    .o_blk_exp           (blk_exp),
    .o_frame_ready       (frame_ready),
    .o_frame_cnt         (frame_cnt),
    .o_err               (err),
    .o_ovf               (ovf),
    .o_dbg_state         (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  int en_phase = 0;

  typedef struct {
    int addr;
    int val;   // bin value in a frame with offset 0
  } rd_vec_t;

  rd_vec_t tbl[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid = 1'b0; tlast = 1'b0; tdata = '0; tuser = '0;
    rd_req = 1'b0; rd_addr = '0; frame_release = 1'b0; aclken = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // blk_exp overlaps index bits [9:8]; the upper six bits come from blk_hi.
  task automatic beat(input int v, input bit last, input int idx, input logic [5:0] blk_hi,
                      input bit gate, input bit rel);
    logic signed [31:0] re_s;
    logic signed [31:0] im_s;
    re_s = v;
    im_s = -v;
    tdata = {im_s, re_s};
    tvalid = 1'b1;
    tlast = last;
    tuser = {blk_hi, 10'(idx)};
    frame_release = rel;
    do begin
      en_phase++;
      aclken = gate ? (en_phase % 3 == 0) : 1'b1;
      tick();
    end while (!aclken);
    frame_release = 1'b0;
  endtask

  task automatic send_frame(input int off, input int nbeats, input int tlast_at, input int bad_at,
                            input logic [5:0] blk_hi, input bit gate, input bit rel_last);
    for (int k = 0; k < nbeats; k++) begin
      beat(k + off, k == tlast_at, (k == bad_at) ? 7 : k, blk_hi, gate, rel_last && (k == tlast_at));
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    aclken = 1'b1;
  endtask

  task automatic release_bank();
    frame_release = 1'b1;
    tick();
    frame_release = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input int v);
    logic [OW-1:0] exp_re;
    logic [OW-1:0] exp_im;
    int nv;
    nv = -v;
    exp_re = v[OW-1:0];
    exp_im = nv[OW-1:0];
    rd_req = 1'b1;
    rd_addr = addr[LOG2-1:0];
    tick();
    rd_req = 1'b0;
    chk({name, ".valid"}, 64'(rd_valid), 64'd1);
    chk({name, ".re"}, 64'(rd_re), 64'(exp_re));
    chk({name, ".im"}, 64'(rd_im), 64'(exp_im));
  endtask

  task automatic read_tbl(input string name, input int off);
    for (int i = 0; i < 5; i++) begin
      read_chk($sformatf("%s[%0d]", name, tbl[i].addr), tbl[i].addr, tbl[i].val + off);
    end
  endtask

  task automatic status(input string name, input bit rdy, input int cnt, input bit e, input bit o);
    chk({name, ".ready"}, 64'(frame_ready), 64'(rdy));
    chk({name, ".cnt"}, 64'(frame_cnt), 64'(cnt));
    chk({name, ".err"}, 64'(err), 64'(e));
    chk({name, ".ovf"}, 64'(ovf), 64'(o));
  endtask

  task automatic all_zero(input string name);
    chk({name, ".outs"}, {rd_valid, rd_re, rd_im, blk_exp, frame_ready, frame_cnt, err, ovf}, 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{addr: 0,    val: 0};
    tbl[1] = '{addr: 5,    val: 5};
    tbl[2] = '{addr: 511,  val: 511};
    tbl[3] = '{addr: 1022, val: 1022};
    tbl[4] = '{addr: 1023, val: 1023};

    do_reset();
    all_zero("reset");
    chk("reset.state", 64'(dbg_state), 64'd0);
    rd_req = 1'b1; rd_addr = 10'd5; tick(); rd_req = 1'b0;
    chk("rd_not_ready.valid", 64'(rd_valid), 64'd0);

    // 1: one good frame
    send_frame(0, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s1", 1'b1, 1, 1'b0, 1'b0);
    chk("s1.blk_exp", 64'(blk_exp), 64'hA7);
    read_tbl("s1", 0);

    // 2: three frames back-to-back, no release
    do_reset();
    send_frame(0, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    send_frame(2000, N, N - 1, -1, 6'h15, 1'b0, 1'b0);
    send_frame(4000, N, N - 1, -1, 6'h3F, 1'b0, 1'b0);
    tick();
    status("s2", 1'b1, 2, 1'b0, 1'b1);
    read_chk("s2.first", 5, 5);
    chk("s2.blk_exp1", 64'(blk_exp), 64'hA7);
    release_bank();
    chk("s2.ready_after_rel", 64'(frame_ready), 64'd1);
    chk("s2.blk_exp2", 64'(blk_exp), 64'h57);
    read_tbl("s2", 2000);
    release_bank();
    chk("s2.ready_empty", 64'(frame_ready), 64'd0);

    // 3: early tlast, then a good frame
    do_reset();
    send_frame(0, 501, 500, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s3.early", 1'b0, 0, 1'b1, 1'b0);
    send_frame(500, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s3.good", 1'b1, 1, 1'b1, 1'b0);
    read_chk("s3.rd", 1023, 1523);

    // 3b: frame overruns N without tlast, tlast one beat later
    do_reset();
    send_frame(0, N + 1, N, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s3b.long", 1'b0, 0, 1'b1, 1'b0);
    chk("s3b.state", 64'(dbg_state), 64'd0);
    send_frame(100, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s3b.good", 1'b1, 1, 1'b1, 1'b0);
    read_chk("s3b.rd", 0, 100);

    // 4: commit and release in the same cycle with one bank held
    do_reset();
    send_frame(0, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    send_frame(3000, N, N - 1, -1, 6'h15, 1'b0, 1'b1);
    tick();
    status("s4", 1'b1, 2, 1'b0, 1'b0);
    chk("s4.blk_exp", 64'(blk_exp), 64'h57);
    read_tbl("s4", 3000);
    release_bank();
    chk("s4.ready_empty", 64'(frame_ready), 64'd0);

    // 5: clock enable high one cycle in three
    do_reset();
    send_frame(0, N, N - 1, -1, 6'h29, 1'b1, 1'b0);
    tick();
    status("s5.gated", 1'b1, 1, 1'b0, 1'b0);
    read_tbl("s5.gated", 0);

    // 5b: reset at beat 300 of a new frame
    send_frame(0, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    send_frame(9000, 300, -1, -1, 6'h29, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    all_zero("s5.in_reset");
    do_reset();
    all_zero("s5.after_reset");
    send_frame(700, N, N - 1, -1, 6'h29, 1'b0, 1'b0);
    tick();
    status("s5.restart", 1'b1, 1, 1'b0, 1'b0);
    read_chk("s5.rd", 5, 705);

    // 6: wrong tuser index at beat 6
    do_reset();
    send_frame(0, N, N - 1, 6, 6'h29, 1'b0, 1'b0);
    tick();
`ifdef IPSXE_FFT_CAPTURE_INDEX_CHK_EN
    status("s6.chk", 1'b0, 0, 1'b1, 1'b0);
`else
    status("s6.nochk", 1'b1, 1, 1'b0, 1'b0);
    read_chk("s6.rd", 6, 6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #3000000;
    $display("FAIL timeout: got no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $finish;
  end

endmodule
